// File: rtl/decode_stage.sv
// RV32I decode/operand-fetch stage for OP and OP-IMM: a single output register slot
// fed from a 2-read/1-write register file with write-back bypass.
package decode_pkg;
  typedef enum logic [2:0] {
    ADD_SUB = 3'b000,
    SLL     = 3'b001,
    SLT     = 3'b010,
    SLTU    = 3'b011,
    XOR     = 3'b100,
    SRL_SRA = 3'b101,
    OR      = 3'b110,
    AND     = 3'b111
  } alu_fn_t;

  typedef logic [6:0] funct7_t;
endpackage

module decode_stage
  import decode_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic             wb_en,
  input  logic [4:0]       wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output alu_fn_t          alu_fn,
  output funct7_t          funct7,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [4:0]       rd,
  output logic             illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam funct7_t    F7_ALT     = 7'b0100000;

  logic [WIDTH-1:0] regs [NUM_REGS];

  logic [6:0]       opc;
  logic [2:0]       f3;
  funct7_t          f7;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [WIDTH-1:0] rs1_val;
  logic [WIDTH-1:0] rs2_val;
  logic             d_legal;
  funct7_t          d_f7;
  logic [WIDTH-1:0] d_b;
  logic             accept;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];

  // Handshake: a beat moves on in_valid && in_ready (input side) and on
  // out_valid && out_ready (output side); the single slot may be refilled
  // on the same edge it drains, so in_ready = !out_valid || out_ready.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Read ports see a same-edge write-back so a dependent instruction needs no stall.
  always_comb begin
    rs1_val = regs[rs1];
    rs2_val = regs[rs2];
    if (wb_en && (wb_addr == rs1)) rs1_val = wb_data;
    if (wb_en && (wb_addr == rs2)) rs2_val = wb_data;
    if (rs1 == 5'd0) rs1_val = '0;
    if (rs2 == 5'd0) rs2_val = '0;
  end

  always_comb begin
    d_legal = 1'b0;
    d_f7    = '0;
    d_b     = '0;
    case (opc)
      OPC_OP: begin
        d_b     = rs2_val;
        d_f7    = f7;
        d_legal = (f7 == '0) || ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
      end
      OPC_OP_IMM: begin
        if (f3 == 3'b001) begin
          d_b     = {{(WIDTH-5){1'b0}}, instr[24:20]};
          d_f7    = f7;
          d_legal = (f7 == '0);
        end else if (f3 == 3'b101) begin
          d_b     = {{(WIDTH-5){1'b0}}, instr[24:20]};
          d_f7    = f7;
          d_legal = (f7 == '0) || (f7 == F7_ALT);
        end else begin
          // funct7 stays zero so ADDI can never be turned into a subtract.
          d_b     = {{(WIDTH-12){instr[31]}}, instr[31:20]};
          d_legal = 1'b1;
        end
      end
      default: d_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      alu_fn    <= ADD_SUB;
      funct7    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      rd        <= '0;
      illegal   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      if (d_legal) begin
        alu_fn  <= alu_fn_t'(f3);
        funct7  <= d_f7;
        op_a    <= rs1_val;
        op_b    <= d_b;
        rd      <= instr[11:7];
        illegal <= 1'b0;
      end else begin
        alu_fn  <= ADD_SUB;
        funct7  <= '0;
        op_a    <= '0;
        op_b    <= '0;
        rd      <= '0;
        illegal <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // x0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_en && (wb_addr != 5'd0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed plan with literal expectations, then random
// traffic checked every cycle against a queue-based behavioural model.
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid, in_ready, wb_en, out_valid, out_ready, illegal;
  logic [31:0] instr, wb_data, op_a, op_b;
  logic [4:0]  wb_addr, rd;
  alu_fn_t     alu_fn;
  funct7_t     funct7;

  always #5 clk = ~clk;

  decode_stage #(.WIDTH(32), .NUM_REGS(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(out_valid),
    .out_ready(out_ready), .alu_fn(alu_fn), .funct7(funct7), .op_a(op_a), .op_b(op_b),
    .rd(rd), .illegal(illegal)
  );

  typedef struct packed {
    logic [2:0]  fn;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        ill;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] rf_m [32];
  bit          m_busy, m_take;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] reg_m(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_en && wb_addr == a) return wb_data;
    return rf_m[a];
  endfunction

  // What the stage should present for one accepted word, straight from the ISA rules.
  function automatic beat_t model(input logic [31:0] w);
    beat_t       r;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic        ok;
    opc = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    r = '0;
    ok = 1'b0;
    r.fn = f3;
    r.rd = w[11:7];
    r.a  = reg_m(w[19:15]);
    if (opc == 7'h33) begin
      r.b = reg_m(w[24:20]);
      r.f7 = f7;
      ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    end else if (opc == 7'h13) begin
      if (f3 == 3'd1 || f3 == 3'd5) begin
        r.b = 32'(w[24:20]);
        r.f7 = f7;
        ok = (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
      end else begin
        r.b = 32'($signed(w[31:20]));
        r.f7 = 7'h00;
        ok = 1'b1;
      end
    end
    if (!ok) begin
      r = '0;
      r.ill = 1'b1;
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
    end else begin
      m_busy = (exp_q.size() != 0);
      m_take = in_valid && (!m_busy || out_ready);
      if (m_busy && out_ready) void'(exp_q.pop_front());
      if (m_take) exp_q.push_back(model(instr));
      if (wb_en && wb_addr != 5'd0) rf_m[wb_addr] = wb_data;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      check("in_ready", 32'(in_ready), 32'(exp_q.size() == 0 || out_ready));
      if (exp_q.size() != 0) begin
        check("alu_fn", 32'(alu_fn), 32'(exp_q[0].fn));
        check("funct7", 32'(funct7), 32'(exp_q[0].f7));
        check("op_a", op_a, exp_q[0].a);
        check("op_b", op_b, exp_q[0].b);
        check("rd", 32'(rd), 32'(exp_q[0].rd));
        check("illegal", 32'(illegal), 32'(exp_q[0].ill));
      end
    end
  end

  task automatic cyc(input bit v, input logic [31:0] w, input bit ordy,
                     input bit we, input logic [4:0] wa, input logic [31:0] wd);
    in_valid = v; instr = w; out_ready = ordy;
    wb_en = we; wb_addr = wa; wb_data = wd;
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] opc, f7;
    int         s;
    s = $urandom_range(0, 9);
    opc = (s < 4) ? 7'h33 : (s < 8) ? 7'h13 : 7'($urandom);
    s = $urandom_range(0, 9);
    f7 = (s < 6) ? 7'h00 : (s < 9) ? 7'h20 : 7'($urandom);
    return {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom),
            5'($urandom_range(1, 7)), opc};
  endfunction

  initial begin
    in_valid = 0; instr = 0; out_ready = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
    #1 rst = 1'b1;
    @(negedge clk); #1;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst alu_fn", 32'(alu_fn), 32'd0);
    check("rst funct7", 32'(funct7), 32'd0);
    check("rst op_a", op_a, 32'd0);
    check("rst op_b", op_b, 32'd0);
    check("rst rd", 32'(rd), 32'd0);
    check("rst illegal", 32'(illegal), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    cyc(1, 32'hFFB00093, 1, 0, 0, 0);
    check("addi out_valid", 32'(out_valid), 32'd1);
    check("addi alu_fn", 32'(alu_fn), 32'd0);
    check("addi funct7", 32'(funct7), 32'd0);
    check("addi op_a", op_a, 32'd0);
    check("addi op_b", op_b, 32'hFFFFFFFB);
    check("addi rd", 32'(rd), 32'd1);

    cyc(0, 0, 1, 1, 1, 32'd7);
    cyc(0, 0, 1, 1, 2, 32'd3);
    cyc(1, 32'h402081B3, 1, 0, 0, 0);
    check("sub op_a", op_a, 32'd7);
    check("sub op_b", op_b, 32'd3);
    check("sub funct7", 32'(funct7), 32'h20);
    check("sub rd", 32'(rd), 32'd3);

    cyc(0, 0, 1, 1, 1, 32'h80000000);
    cyc(1, 32'h4040D293, 1, 0, 0, 0);
    check("srai alu_fn", 32'(alu_fn), 32'd5);
    check("srai funct7", 32'(funct7), 32'h20);
    check("srai op_a", op_a, 32'h80000000);
    check("srai op_b", op_b, 32'd4);
    check("srai illegal", 32'(illegal), 32'd0);

    cyc(1, 32'h00008233, 1, 1, 1, 32'h1234);
    check("bypass op_a", op_a, 32'h1234);
    cyc(1, 32'h00000233, 1, 1, 0, 32'hDEAD);
    check("x0 same-edge op_a", op_a, 32'd0);
    cyc(1, 32'h00000233, 1, 0, 0, 0);
    check("x0 op_a", op_a, 32'd0);
    cyc(1, 32'h00008233, 1, 0, 0, 0);
    check("x1 kept op_a", op_a, 32'h1234);

    cyc(1, 32'h06400313, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 32'h00100393, 0, 1, 6, 32'hBEEF);
      check("stall in_ready", 32'(in_ready), 32'd0);
      check("stall out_valid", 32'(out_valid), 32'd1);
      check("stall rd", 32'(rd), 32'd6);
      check("stall op_b", op_b, 32'd100);
    end
    cyc(1, 32'h00100393, 1, 0, 0, 0);
    check("release out_valid", 32'(out_valid), 32'd1);
    check("release rd", 32'(rd), 32'd7);
    check("release op_b", op_b, 32'd1);

    cyc(0, 0, 1, 1, 1, 32'h55);
    cyc(1, 32'h00002083, 1, 0, 0, 0);
    check("load illegal", 32'(illegal), 32'd1);
    check("load rd", 32'(rd), 32'd0);
    check("load op_a", op_a, 32'd0);
    cyc(0, 0, 0, 0, 0, 0);
    check("held out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("async rst out_valid", 32'(out_valid), 32'd0);
    #1 rst = 1'b0;
    cyc(1, 32'h00008233, 1, 0, 0, 0);
    check("post-rst x1", op_a, 32'd0);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        #1 rst = 1'b0;
      end
      cyc($urandom_range(0, 9) < 7, rand_instr(), $urandom_range(0, 9) < 7,
          $urandom_range(0, 1) == 1, 5'($urandom_range(0, 4)), $urandom);
    end
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Single-entry decode/operand-fetch stage directly upstream of the ALU. It accepts a 32-bit RV32I instruction word over a valid/ready handshake and decodes OP (0110011) and OP-IMM (0010011) instructions. It reads two operands from an internal 2-read/1-write register file and presents a registered alu_fn_t, funct7_t and operand pair to the ALU, with one cycle of latency. The write-back port into the register file is driven by the downstream write-back stage.

Parameters:
WIDTH, 32, datapath/register width in bits; also the ALU WIDTH.
NUM_REGS, 32, architectural register count; register addresses are 5 bits.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  instr is valid.
in_ready  output  1  stage can accept instr this cycle.
instr  input  32  RV32I instruction word.
wb_en  input  1  register-file write enable.
wb_addr  input  5  register-file write address.
wb_data  input  WIDTH  register-file write data.
out_valid  output  1  registered ALU operands are valid.
out_ready  input  1  ALU/downstream consumes the output this cycle.
alu_fn  output  alu_fn_t  funct3-derived ALU function.
funct7  output  funct7_t  funct7 qualifier for ADD_SUB and SRL_SRA.
op_a  output  WIDTH  ALU operand a.
op_b  output  WIDTH  ALU operand b.
rd  output  5  destination register for write-back.
illegal  output  1  instruction is not a legal OP/OP-IMM.

Behaviour:
- Reset (async, rst=1):
  - out_valid=0; alu_fn=ADD_SUB; funct7=0; op_a=op_b=0; rd=0; illegal=0.
  - All register-file entries are cleared to 0.
  - A transaction in flight during reset is discarded.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready; decoded outputs are registered on that edge, so latency is 1 cycle.
  - Output transfer happens on out_valid && out_ready.
  - On that edge out_valid stays 1 if a new instruction is accepted, else it clears to 0.
  - While out_valid && !out_ready, all outputs hold stable.
- Register file:
  - x0 always reads 0; writes to x0 are ignored.
  - A write occurs on the edge when wb_en=1, independent of the handshake.
  - Same-cycle bypass: if wb_en && wb_addr==rs && rs!=0 on the accepting edge, the operand takes wb_data.
  - Operands are captured only at acceptance. Later writes do not alter a stalled output.
- Decode, common: rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7], alu_fn=instr[14:12], op_a=x[rs1].
- Decode, OP:
  - op_b=x[rs2]; funct7=instr[31:25].
  - Legal iff funct7=0000000, or funct7=0100000 with funct3 in {000,101}.
- Decode, OP-IMM, funct3 000/010/011/100/110/111:
  - op_b = sign-extended instr[31:20].
  - funct7 is forced to 0000000, so ADDI never subtracts.
- Decode, OP-IMM, funct3 001/101 (shifts):
  - op_b = zero-extended instr[24:20]; funct7=instr[31:25].
  - 001 is legal only with funct7=0000000.
  - 101 is legal with 0000000 or 0100000 (SRAI).
- Illegal instructions:
  - Any other opcode, or a funct7 violation, is still accepted and produces an output beat.
  - That beat carries illegal=1, rd=0, alu_fn=ADD_SUB, funct7=0, op_a=op_b=0.
- Simultaneous events: acceptance, output transfer and register write can all occur on the same edge. Each takes effect as specified above, with no extra bubble.

Test Plan:
- Reset, then ADDI x1,x0,-5 (0xFFB00093) with out_ready=1 -> next cycle out_valid=1, alu_fn=000, funct7=0, op_a=0, op_b=0xFFFFFFFB, rd=1.
- Write x1=7, x2=3 via wb port, then SUB x3,x1,x2 (0x402081B3) -> op_a=7, op_b=3, funct7=0100000, rd=3.
- SRAI x5,x1,4 (0x4040D293) with x1=0x80000000 -> alu_fn=101, funct7=0100000, op_b=4, illegal=0.
- Bypass: ADD x4,x1,x0 (0x00008233) accepted in the same cycle as wb_en=1, wb_addr=1, wb_data=0x1234 -> op_a=0x1234. Then write x0=0xDEAD and issue ADD x4,x0,x0 -> op_a=0.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs unchanged. On the cycle out_ready=1, the next instruction is accepted and out_valid stays 1.
- Illegal: load 0x00002083 -> illegal=1, rd=0. Assert rst while out_valid=1 and out_ready=0 -> out_valid=0 immediately and x1 reads 0 afterwards.
